// File: rtl/ccu_line_lock_arbiter.sv
// Line-lock arbiter in front of the CCU: one lock entry per port, round-robin grants
// among non-conflicting requesters, and starvation protection. Define CCU_LOCK_STATS_EN
// to add per-port stall counters on stall_cnt_o.
module ccu_line_lock_arbiter #(
  parameter int unsigned NoPorts      = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned LineOffset   = 6,
  parameter int unsigned MaxWait      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NoPorts-1:0]              req_valid_i,
  input  logic [NoPorts*AxiAddrWidth-1:0] req_addr_i,
  input  logic [NoPorts-1:0]              req_write_i,
  output logic [NoPorts-1:0]              req_ready_o,
  input  logic [NoPorts-1:0]              done_i,
  output logic [NoPorts-1:0]              busy_o
`ifdef CCU_LOCK_STATS_EN
  ,
  output logic [NoPorts*32-1:0]           stall_cnt_o
`endif
);

  localparam int unsigned LineWidth = AxiAddrWidth - LineOffset;
  localparam int unsigned PtrWidth  = $clog2(NoPorts);
  localparam int unsigned CntWidth  = $clog2(MaxWait + 1);

  typedef logic [LineWidth-1:0] line_t;
  typedef logic [PtrWidth-1:0]  ptr_t;
  typedef logic [CntWidth-1:0]  cnt_t;

  localparam cnt_t WaitMax = cnt_t'(MaxWait);

  // Lock table
  logic [NoPorts-1:0] entry_valid;
  line_t              entry_line [NoPorts];
  logic [NoPorts-1:0] entry_write;

  ptr_t rr_ptr;
  cnt_t wait_cnt [NoPorts];

  line_t              req_line [NoPorts];
  logic [NoPorts-1:0] eligible;
  logic [NoPorts-1:0] starve_block;
  logic [NoPorts-1:0] candidate;
  logic [NoPorts-1:0] grant;
  logic [NoPorts-1:0] handshake;
  logic               any_starving;
  ptr_t               starve_idx;
  logic               win_found;
  ptr_t               win_idx;
  logic               addr_unused;

  function automatic ptr_t wrap_idx(ptr_t base, int off);
    return ptr_t'((int'(base) + off) % NoPorts);
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_unused = 1'b0;
    for (int i = 0; i < NoPorts; i++) begin
      req_line[i] = req_addr_i[i*AxiAddrWidth+LineOffset +: LineWidth];
      addr_unused = addr_unused ^ (^req_addr_i[i*AxiAddrWidth +: LineOffset]);
    end
  end

  // A port may lock only when its own entry is free (a same-cycle done does not count)
  // and no other held line clashes with it; read/read sharing is allowed.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NoPorts; i++) begin
      eligible[i] = req_valid_i[i] & ~entry_valid[i];
      for (int j = 0; j < NoPorts; j++) begin
        if (j != i && entry_valid[j] && entry_line[j] == req_line[i] &&
            (req_write_i[i] | entry_write[j])) begin
          eligible[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    any_starving = 1'b0;
    starve_idx   = '0;
    for (int i = NoPorts - 1; i >= 0; i--) begin
      if (wait_cnt[i] == WaitMax) begin
        any_starving = 1'b1;
        starve_idx   = ptr_t'(i);
      end
    end
  end

  // Ports that would compete for the starving port's line are held back until it wins.
  always_comb begin
    starve_block = '0;
    for (int k = 0; k < NoPorts; k++) begin
      if (any_starving && ptr_t'(k) != starve_idx &&
          req_line[k] == req_line[starve_idx] &&
          (req_write_i[k] | req_write_i[starve_idx])) begin
        starve_block[k] = 1'b1;
      end
    end
    candidate = eligible & ~starve_block;
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    grant     = '0;
    if (any_starving && eligible[starve_idx]) begin
      win_found = 1'b1;
      win_idx   = starve_idx;
    end else begin
      for (int off = 0; off < NoPorts; off++) begin
        if (!win_found && candidate[wrap_idx(rr_ptr, off)]) begin
          win_found = 1'b1;
          win_idx   = wrap_idx(rr_ptr, off);
        end
      end
    end
    // Grants are suppressed while reset is asserted so nothing handshakes mid-reset.
    if (win_found && rst_ni) grant[win_idx] = 1'b1;
  end

  assign req_ready_o = grant;
  assign handshake   = req_valid_i & grant;
  assign busy_o      = entry_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order. The lock table is a handful of
  // flops, not a RAM, so all fields are reset along with the valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_valid <= '0;
      entry_write <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < NoPorts; i++) begin
        entry_line[i] <= '0;
        wait_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NoPorts; i++) begin
        if (handshake[i]) begin
          entry_valid[i] <= 1'b1;
          entry_line[i]  <= req_line[i];
          entry_write[i] <= req_write_i[i];
        end else if (done_i[i] && entry_valid[i]) begin
          entry_valid[i] <= 1'b0;
        end

        if (req_valid_i[i] && !grant[i]) begin
          if (wait_cnt[i] != WaitMax) wait_cnt[i] <= wait_cnt[i] + cnt_t'(1);
        end else begin
          wait_cnt[i] <= '0;
        end
      end

      if (|handshake) rr_ptr <= wrap_idx(win_idx, 1);
    end
  end

`ifdef CCU_LOCK_STATS_EN
  logic [31:0] stall_cnt [NoPorts];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NoPorts; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NoPorts; i++) begin
        if (req_valid_i[i] && !grant[i] && stall_cnt[i] != 32'hFFFF_FFFF) begin
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int i = 0; i < NoPorts; i++) stall_cnt_o[i*32 +: 32] = stall_cnt[i];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ccu_line_lock_arbiter.sv
// Directed bench for ccu_line_lock_arbiter (MaxWait=4): locking, conflicts, round-robin,
// starvation override and asynchronous reset, with hand-computed expectations.
module tb_ccu_line_lock_arbiter;

  localparam int NoPorts = 4;
  localparam int AW      = 64;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [NoPorts-1:0]      req_valid_i = '0;
  logic [NoPorts*AW-1:0]   req_addr_i = '0;
  logic [NoPorts-1:0]      req_write_i = '0;
  logic [NoPorts-1:0]      req_ready_o;
  logic [NoPorts-1:0]      done_i = '0;
  logic [NoPorts-1:0]      busy_o;
`ifdef CCU_LOCK_STATS_EN
  logic [NoPorts*32-1:0]   stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  ccu_line_lock_arbiter #(
    .NoPorts(NoPorts), .AxiAddrWidth(AW), .LineOffset(6), .MaxWait(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_ready_o(req_ready_o), .done_i(done_i), .busy_o(busy_o)
`ifdef CCU_LOCK_STATS_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [63:0] a, input logic w);
    req_valid_i[p]        = v;
    req_addr_i[p*AW +: AW] = a;
    req_write_i[p]        = w;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_write_i = '0;
    done_i      = '0;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset state
    rst_ni = 1'b0;
    step();
    check("reset_busy", 64'(busy_o), 64'h0);
    check("reset_ready", 64'(req_ready_o), 64'h0);
    rst_ni = 1'b1;

    // 1: write lock granted same cycle, busy next cycle
    set_req(0, 1'b1, 64'h1000, 1'b1);
    settle();
    check("t1_ready", 64'(req_ready_o), 64'h1);
    step();
    set_req(0, 1'b0, 64'h0, 1'b0);
    settle();
    check("t1_busy", 64'(busy_o), 64'h1);
    check("t1_ready_idle", 64'(req_ready_o), 64'h0);

    // 2: read of the same line blocked by write; done releases it
    set_req(1, 1'b1, 64'h1008, 1'b0);
    settle();
    check("t2_blocked", 64'(req_ready_o), 64'h0);
    step();
    done_i[0] = 1'b1;
    settle();
    check("t2_done_same_cycle", 64'(req_ready_o), 64'h0);
    step();
    done_i[0] = 1'b0;
    settle();
    check("t2_busy_released", 64'(busy_o), 64'h0);
    check("t2_ready1", 64'(req_ready_o), 64'h2);
    step();
    set_req(1, 1'b0, 64'h0, 1'b0);
    settle();
    check("t2_busy1", 64'(busy_o), 64'h2);
`ifdef CCU_LOCK_STATS_EN
    check("t2_stall1", 64'(stall_cnt_o[32 +: 32]), 64'd2);
`endif

    // 3: read/read sharing, round-robin order 1 then 2
    do_reset();
    set_req(1, 1'b1, 64'h2000, 1'b0);
    set_req(2, 1'b1, 64'h2000, 1'b0);
    settle();
    check("t3_first", 64'(req_ready_o), 64'h2);
    step();
    set_req(1, 1'b0, 64'h0, 1'b0);
    settle();
    check("t3_second", 64'(req_ready_o), 64'h4);
    step();
    set_req(2, 1'b0, 64'h0, 1'b0);
    settle();
    check("t3_busy", 64'(busy_o), 64'h6);

    // 4: four distinct lines granted on consecutive cycles, pointer wraps
    do_reset();
    for (int i = 0; i < NoPorts; i++) set_req(i, 1'b1, 64'h10000 * (i + 1), 1'b1);
    for (int k = 0; k < NoPorts; k++) begin
      settle();
      check($sformatf("t4_grant%0d", k), 64'(req_ready_o), 64'(1) << k);
      step();
      set_req(k, 1'b0, 64'h0, 1'b0);
    end
    settle();
    check("t4_busy_all", 64'(busy_o), 64'hF);
    done_i = 4'hF;
    step();
    done_i = 4'h0;
    settle();
    check("t4_busy_none", 64'(busy_o), 64'h0);
    set_req(0, 1'b1, 64'h50000, 1'b0);
    set_req(3, 1'b1, 64'h60000, 1'b0);
    settle();
    check("t4_wrap", 64'(req_ready_o), 64'h1);

    // 5: starvation of a writer behind a stream of readers
    do_reset();
    set_req(0, 1'b1, 64'h3000, 1'b0);
    settle();
    check("t5_p0_lock", 64'(req_ready_o), 64'h1);
    step();
    set_req(0, 1'b0, 64'h0, 1'b0);
    set_req(3, 1'b1, 64'h3000, 1'b1);
    set_req(1, 1'b1, 64'h3000, 1'b0);
    settle();
    check("t5_p1_share", 64'(req_ready_o), 64'h2);      // port3 wait 0 -> 1
    step();
    req_valid_i[1] = 1'b0;
    done_i[1]      = 1'b1;
    settle();
    check("t5_p3_wait2", 64'(req_ready_o), 64'h0);      // wait 1 -> 2
    step();
    req_valid_i[1] = 1'b1;
    done_i[1]      = 1'b0;
    settle();
    check("t5_p1_reissue", 64'(req_ready_o), 64'h2);    // wait 2 -> 3
    step();
    req_valid_i[1] = 1'b0;
    done_i[1]      = 1'b1;
    settle();
    check("t5_p3_wait4", 64'(req_ready_o), 64'h0);      // wait 3 -> 4
    step();
    req_valid_i[1] = 1'b1;
    done_i[1]      = 1'b0;
    settle();
    check("t5_p1_held_back", 64'(req_ready_o), 64'h0);
    check("t5_busy_p0", 64'(busy_o), 64'h1);
    step();
    done_i[0] = 1'b1;
    settle();
    check("t5_p1_held_back2", 64'(req_ready_o), 64'h0);
    step();
    done_i[0] = 1'b0;
    settle();
    check("t5_p3_granted", 64'(req_ready_o), 64'h8);
    step();
    set_req(3, 1'b0, 64'h0, 1'b0);
    settle();
    check("t5_p3_busy", 64'(busy_o), 64'h8);
    check("t5_p1_vs_write", 64'(req_ready_o), 64'h0);

    // 6: asynchronous reset with all locks held
    do_reset();
    for (int i = 0; i < NoPorts; i++) set_req(i, 1'b1, 64'h40000 * (i + 1), 1'b0);
    repeat (NoPorts) step();
    settle();
    check("t6_busy_all", 64'(busy_o), 64'hF);
    check("t6_ready_none", 64'(req_ready_o), 64'h0);
    rst_ni = 1'b0;
    settle();
    check("t6_busy_reset", 64'(busy_o), 64'h0);
    check("t6_ready_reset", 64'(req_ready_o), 64'h0);
`ifdef CCU_LOCK_STATS_EN
    check("t6_stall_reset", 64'(|stall_cnt_o), 64'h0);
`endif
    step();
    rst_ni = 1'b1;
    settle();
    check("t6_after_reset", 64'(req_ready_o), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
